// File: rtl/fxp32_acc_ctrl.sv
// fxp32_acc_ctrl: streaming accumulate-and-dump controller wrapped around the fxp32 adder.
// Accumulates ACC_LEN signed 32-bit samples per frame and presents each frame total
// on a valid/ready port; out_sat reports that at least one add in the frame overflowed.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data/in_sub sample stream;
// out_valid/out_ready/out_data/out_sat result stream; add_a/add_b/add_cin drive the
// external adder, add_s/add_overflow are its combinational results.
// Build option: define FXP32_ACC_SAT_EN to saturate on overflow; otherwise sums wrap.
module fxp32_acc_ctrl #(
    parameter int ACC_LEN = 16,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_sat,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_cin,
    input  logic [31:0] add_s,
    input  logic        add_overflow
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t           state;
    logic [31:0]      acc;
    logic [CNT_W-1:0] cnt;
    logic             sat_flag;
    logic             accept;
    logic             last;
    logic             sat_nxt;
    logic [31:0]      nxt;
    assign in_ready = state != DONE;
    assign accept   = in_valid && in_ready;
    // Subtraction is A + ~B + 1, so the adder never needs to know about in_sub.
    assign add_a    = state == IDLE ? 32'd0 : acc;
    assign add_b    = in_sub ? ~in_data : in_data;
    assign add_cin  = in_sub;
`ifdef FXP32_ACC_SAT_EN
    // A signed overflow can only push past the rail that operand A's sign points to.
    assign nxt = add_overflow ? (add_a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : add_s;
`else
    assign nxt = add_s;
`endif
    // cnt holds samples already taken this frame, so the accepted one is cnt+1.
    assign last    = cnt == CNT_W'(ACC_LEN - 1);
    assign sat_nxt = (state == ACCUM && sat_flag) || add_overflow;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            sat_flag  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc      <= nxt;
                        cnt      <= cnt + 1'b1;
                        sat_flag <= sat_nxt;
                        if (last) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_data  <= nxt;
                            out_sat   <= sat_nxt;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        cnt       <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fxp32_acc_ctrl.sv
// tb_fxp32_acc_ctrl: scoreboard bench driving three controllers (ACC_LEN 4, 1, 3) from one stream.
module tb_fxp32_acc_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sub = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;
    int          errs = 0;
    int          checks = 0;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int G = g;
        localparam int L = g == 0 ? 4 : g == 1 ? 1 : 3;
        logic        in_ready, out_valid, out_sat, add_cin, add_overflow;
        logic [31:0] out_data, add_a, add_b, add_s;
        int          e = 0;
        int          c = 0;
        int          cnt = 0;
        logic        done = 1'b0;
        logic [31:0] acc = '0;
        logic        sat = 1'b0;
        logic [31:0] qd[$];
        logic        qs[$];
        logic [31:0] last_d = '0;
        logic        last_s = 1'b0;
        longint      ma, mr;
        logic        mov;

        assign add_s        = add_a + add_b + {31'd0, add_cin};
        assign add_overflow = add_a[31] == add_b[31] && add_s[31] != add_a[31];

        fxp32_acc_ctrl #(.ACC_LEN(L), .CNT_W(16)) dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sub(in_sub),
            .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
            .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
            .add_s(add_s), .add_overflow(add_overflow)
        );

        task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
            c++;
            if (got !== exp) begin
                e++;
                $display("FAIL inst%0d(len=%0d) %s: got %h expected %h", G, L, n, got, exp);
            end
        endtask

        // Reference model: frame arithmetic in wide signed integers, pushing each frame total.
        initial forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                cnt = 0;
                done = 1'b0;
                acc = '0;
                sat = 1'b0;
                qd.delete();
                qs.delete();
            end else if (done) begin
                if (out_ready) begin
                    done = 1'b0;
                    cnt = 0;
                end
            end else if (in_valid) begin
                ma = cnt == 0 ? 64'sd0 : longint'($signed(acc));
                mr = ma + (in_sub ? -longint'($signed(in_data)) : longint'($signed(in_data)));
                mov = mr > MAXV || mr < MINV;
`ifdef FXP32_ACC_SAT_EN
                acc = mov ? (mr > MAXV ? 32'h7FFF_FFFF : 32'h8000_0000) : mr[31:0];
`else
                acc = mr[31:0];
`endif
                sat = (cnt == 0 ? 1'b0 : sat) | mov;
                cnt++;
                if (cnt == L) begin
                    done = 1'b1;
                    qd.push_back(acc);
                    qs.push_back(sat);
                end
            end
        end

        // Monitor: compares handshake/operand outputs every cycle, pops on output handshake.
        initial forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset out_data", out_data, 32'd0);
                chk("reset out_sat", 32'(out_sat), 32'd0);
            end
            chk("out_valid", 32'(out_valid), 32'(done));
            chk("in_ready", 32'(in_ready), 32'(!done));
            chk("add_a", add_a, (cnt == 0 && !done) ? 32'd0 : acc);
            chk("add_b", add_b, in_sub ? ~in_data : in_data);
            chk("add_cin", 32'(add_cin), 32'(in_sub));
            if (done) begin
                if (qd.size() == 0) begin
                    c++;
                    e++;
                    $display("FAIL inst%0d scoreboard: got empty queue expected a frame", G);
                end else begin
                    chk("out_data", out_data, qd[0]);
                    chk("out_sat", 32'(out_sat), 32'(qs[0]));
                    if (out_ready) begin
                        last_d = qd.pop_front();
                        last_s = qs.pop_front();
                    end
                end
            end
        end

        // Reset must clear the outputs without waiting for a clock edge.
        initial forever begin
            @(negedge rst_n);
            #1;
            chk("async out_valid", 32'(out_valid), 32'd0);
            chk("async out_data", out_data, 32'd0);
            chk("async out_sat", 32'(out_sat), 32'd0);
        end
    end

    task automatic kat(string n, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    task automatic drive(logic v, logic [31:0] d, logic s, logic r);
        @(posedge clk);
        #1;
        in_valid = v;
        in_data = d;
        in_sub = s;
        out_ready = r;
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b0, $urandom, 1'($urandom_range(0, 1)), 1'b1);
    endtask

    task automatic do_reset;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($urandom_range(0, 255));
            2: return 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
            default: return 32'h8000_0000 + 32'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        int n;
        logic v;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        // Four adds, back to back
        drive(1'b1, 32'h0001_0000, 1'b0, 1'b1);
        drive(1'b1, 32'h0002_0000, 1'b0, 1'b1);
        drive(1'b1, 32'h0003_0000, 1'b0, 1'b1);
        drive(1'b1, 32'h0004_0000, 1'b0, 1'b1);
        idle(4);
        kat("sum4 data", u[0].last_d, 32'h000A_0000);
        kat("sum4 sat", 32'(u[0].last_s), 32'd0);
        // Positive overflow
        do_reset;
        drive(1'b1, 32'h7FFF_0000, 1'b0, 1'b1);
        drive(1'b1, 32'h0002_0000, 1'b0, 1'b1);
        drive(1'b1, 32'h0000_0000, 1'b0, 1'b1);
        drive(1'b1, 32'h0000_0000, 1'b0, 1'b1);
        idle(4);
`ifdef FXP32_ACC_SAT_EN
        kat("pos ovf data", u[0].last_d, 32'h7FFF_FFFF);
`else
        kat("pos ovf data", u[0].last_d, 32'h8001_0000);
`endif
        kat("pos ovf sat", 32'(u[0].last_s), 32'd1);
        // Single-sample frame subtracting the most negative value, then a clean frame
        do_reset;
        drive(1'b1, 32'h8000_0000, 1'b1, 1'b1);
        idle(3);
`ifdef FXP32_ACC_SAT_EN
        kat("len1 sub min data", u[1].last_d, 32'h7FFF_FFFF);
`else
        kat("len1 sub min data", u[1].last_d, 32'h8000_0000);
`endif
        kat("len1 sub min sat", 32'(u[1].last_s), 32'd1);
        drive(1'b1, 32'h0000_0005, 1'b0, 1'b1);
        idle(3);
        kat("len1 next data", u[1].last_d, 32'h0000_0005);
        kat("len1 next sat", 32'(u[1].last_s), 32'd0);
        // Output backpressure with input held valid
        do_reset;
        drive(1'b1, 32'd7, 1'b0, 1'b1);
        drive(1'b1, 32'd8, 1'b0, 1'b1);
        drive(1'b1, 32'd9, 1'b0, 1'b1);
        repeat (6) drive(1'b1, pick(), 1'($urandom_range(0, 1)), 1'b0);
        drive(1'b1, 32'd100, 1'b0, 1'b1);
        drive(1'b1, 32'd1, 1'b0, 1'b1);
        kat("stall frame data", u[2].last_d, 32'd24);
        drive(1'b1, 32'd2, 1'b0, 1'b1);
        drive(1'b1, 32'd3, 1'b0, 1'b1);
        idle(3);
        kat("post stall data", u[2].last_d, 32'd6);
        kat("post stall sat", 32'(u[2].last_s), 32'd0);
        // Reset mid-frame after two accepts with random gaps
        do_reset;
        n = 0;
        while (n < 2) begin
            v = 1'($urandom_range(0, 1));
            drive(v, 32'h0000_1000, 1'b0, 1'b1);
            n += int'(v);
        end
        do_reset;
        for (int i = 1; i <= 4; i++) begin
            repeat ($urandom_range(0, 2)) drive(1'b0, $urandom, 1'b0, 1'b1);
            drive(1'b1, 32'(i), 1'b0, 1'b1);
        end
        idle(4);
        kat("after reset data", u[0].last_d, 32'd10);
        kat("after reset sat", 32'(u[0].last_s), 32'd0);
        // Mixed add/sub ending in the most negative value
        do_reset;
        drive(1'b1, 32'd10, 1'b0, 1'b1);
        drive(1'b1, 32'd3, 1'b1, 1'b1);
        drive(1'b1, 32'hFFFF_FFFB, 1'b1, 1'b1);
        drive(1'b1, 32'h8000_0000, 1'b0, 1'b1);
        idle(4);
        kat("mixed data", u[0].last_d, 32'h8000_000C);
        kat("mixed sat", 32'(u[0].last_s), 32'd0);
        // Random traffic
        do_reset;
        repeat (400)
            drive($urandom_range(0, 3) != 0, pick(), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        idle(6);
        errs += u[0].e + u[1].e + u[2].e;
        checks += u[0].c + u[1].c + u[2].c;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
